// File: rtl/distance_fan_ctrl.sv
// Presence-gated fan controller: classifies ranging distance with hysteresis, confirms presence,
// holds the fan after departure, and drives an 8-bit PWM at a user-selected duty.
module distance_fan_ctrl #(
    parameter int unsigned MS_CYCLES  = 100_000,
    parameter int unsigned NEAR_CM    = 30,
    parameter int unsigned FAR_CM     = 50,
    parameter int unsigned CONFIRM_MS = 500,
    parameter int unsigned HOLD_MS    = 3000,
    parameter int unsigned PWM_DIV    = 40
) (
    input  logic        clk_i,
    input  logic        reset_p_i,
    input  logic [15:0] distance_cm_i,
    input  logic        fan_en_i,
    input  logic [1:0]  speed_sel_i,
    output logic        pwm_out_o,
    output logic        fan_on_o,
    output logic [3:0]  state_led_o,
    output logic [7:0]  duty_o
);

    localparam int unsigned MsW    = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int unsigned DivW   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned CntMax = (HOLD_MS > CONFIRM_MS) ? HOLD_MS : CONFIRM_MS;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [MsW-1:0]  MsLast     = MsW'(MS_CYCLES - 1);
    localparam logic [DivW-1:0] DivLast    = DivW'(PWM_DIV - 1);
    localparam logic [CntW-1:0] ConfirmLim = CntW'(CONFIRM_MS);
    localparam logic [CntW-1:0] HoldLim    = CntW'(HOLD_MS);
    localparam logic [15:0]     NearLim    = 16'(NEAR_CM);
    localparam logic [15:0]     FarLim     = 16'(FAR_CM);

    typedef enum logic [1:0] {StOff, StArm, StRun, StHold} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [MsW-1:0]  ms_cnt_q, ms_cnt_d;
    logic [DivW-1:0] pre_q, pre_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [7:0]      duty_q, duty_d, target;
    logic [3:0]      state_led_q, state_led_d;
    logic            near_q, near_d, far_q, far_d;
    logic            fan_on_q, fan_on_d, pwm_out_q, pwm_out_d;
    logic            tick_ms, pwm_step;

    always_comb begin
        near_d    = (distance_cm_i != 16'd0) && (distance_cm_i < NearLim);
        far_d     = (distance_cm_i == 16'd0) || (distance_cm_i >= FarLim);
        tick_ms   = (ms_cnt_q == MsLast);
        ms_cnt_d  = tick_ms ? '0 : ms_cnt_q + MsW'(1);
        pwm_step  = (pre_q == DivLast);
        pre_d     = pwm_step ? '0 : pre_q + DivW'(1);
        pwm_cnt_d = pwm_step ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

    // Band samples (neither near nor far) fall through every branch, freezing cnt.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
        if (!fan_en_i) begin
            state_d = StOff;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StOff: begin
                    cnt_d = '0;
                    if (near_q) state_d = StArm;
                end
                StArm: begin
                    if (tick_ms && near_q) begin
                        if (cnt_inc >= ConfirmLim) begin
                            state_d = StRun;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (tick_ms && far_q) begin
                        state_d = StOff;
                        cnt_d   = '0;
                    end
                end
                StRun: begin
                    if (far_q) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end
                end
                StHold: begin
                    if (near_q) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else if (tick_ms && far_q) begin
                        if (cnt_inc >= HoldLim) begin
                            state_d = StOff;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = StOff;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        fan_on_d = (state_d == StRun) || (state_d == StHold);
        case (state_d)
            StOff:   state_led_d = 4'b0001;
            StArm:   state_led_d = 4'b0010;
            StRun:   state_led_d = 4'b0100;
            default: state_led_d = 4'b1000;
        endcase
        case (speed_sel_i)
            2'd0:    target = 8'd0;
            2'd1:    target = 8'd85;
            2'd2:    target = 8'd170;
            default: target = 8'd255;
        endcase
        // Duty reloads only when the next PWM step is 0, so a period never changes shape.
        if (!fan_on_d)               duty_d = 8'd0;
        else if (pwm_cnt_d == 8'd0)  duty_d = target;
        else                         duty_d = duty_q;
        pwm_out_d = (pwm_cnt_d < duty_d);
    end

    always_ff @(posedge clk_i) begin
        if (reset_p_i) begin
            state_q     <= StOff;
            cnt_q       <= '0;
            ms_cnt_q    <= '0;
            pre_q       <= '0;
            pwm_cnt_q   <= 8'd0;
            duty_q      <= 8'd0;
            state_led_q <= 4'b0001;
            near_q      <= 1'b0;
            far_q       <= 1'b0;
            fan_on_q    <= 1'b0;
            pwm_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ms_cnt_q    <= ms_cnt_d;
            pre_q       <= pre_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_q      <= duty_d;
            state_led_q <= state_led_d;
            near_q      <= near_d;
            far_q       <= far_d;
            fan_on_q    <= fan_on_d;
            pwm_out_q   <= pwm_out_d;
        end
    end

    assign pwm_out_o   = pwm_out_q;
    assign fan_on_o    = fan_on_q;
    assign state_led_o = state_led_q;
    assign duty_o      = duty_q;

endmodule

// File: doc/distance_fan_ctrl.md
Name: distance_fan_ctrl

Overview:
- Downstream consumer of the ultrasonic ranging stage's 16-bit distance_cm result.
- Decides whether a person is in front of the fan using a near/far hysteresis window, a confirm delay and an auto-off hold timer.
- Drives the fan motor with an 8-bit PWM whose duty is set by a user speed selection.
- Sits between the ranging block and the fan driver pin / LED status bar.

Parameters:
MS_CYCLES, 100_000, clk cycles per 1 ms tick (100 MHz clock)
NEAR_CM, 30, distance strictly below this counts as "near"
FAR_CM, 50, distance at or above this (or 0) counts as "far"; must be > NEAR_CM
CONFIRM_MS, 500, consecutive near ms-ticks required to start the fan
HOLD_MS, 3000, consecutive far ms-ticks in HOLD before the fan stops
PWM_DIV, 40, clk cycles per PWM counter step (about 9.8 kHz PWM at 100 MHz)

Ports:
clk  in  1  system clock
reset_p  in  1  synchronous active-high reset
distance_cm  in  16  latest distance from the ranging stage, in cm; 0 = no echo
fan_en  in  1  user master enable; 0 forces OFF
speed_sel  in  2  user speed: 0 stop, 1 low, 2 mid, 3 high
pwm_out  out  1  fan PWM drive
fan_on  out  1  1 while in RUN or HOLD
state_led  out  4  one-hot state: [0] OFF, [1] ARM, [2] RUN, [3] HOLD
duty  out  8  currently applied PWM duty

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on posedge clk.
- Reset values: state OFF, pwm_out 0, fan_on 0, state_led 4'b0001, duty 0, all counters 0.

Input classification (registered, 1-cycle latency):
- near = (distance_cm != 0) && (distance_cm < NEAR_CM).
- far = (distance_cm == 0) || (distance_cm >= FAR_CM).
- Values between the thresholds are neither near nor far. They freeze the ARM/HOLD counters; the counters neither advance nor clear.

ms tick:
- Free-running counter 0..MS_CYCLES-1.
- Pulses tick_ms for one clk when it wraps.

State machine (transitions evaluated every clk; counters advance only on tick_ms):
- OFF: cnt = 0. Go to ARM when fan_en && near.
- ARM: on tick_ms, near increments cnt; far returns to OFF and clears cnt. When cnt reaches CONFIRM_MS, go to RUN and clear cnt.
- RUN: if far, go to HOLD with cnt = 0.
- HOLD: on tick_ms, far increments cnt. A near sample returns to RUN and clears cnt. When cnt reaches HOLD_MS, go to OFF.
- fan_en = 0 in any state: next state OFF, cnt cleared, pwm_out low on the next cycle. This has priority over all other transitions.
- Simultaneous near and a counter terminal event cannot occur, because near and far are exclusive.
- Counter widths must hold HOLD_MS without wrap. Counters saturate and never wrap.

Duty selection (registered):
- target = 0, 85, 170 or 255 for speed_sel 0..3.
- duty = target while fan_on, else 0.
- speed_sel changes take effect at the next PWM period start (pwm_cnt == 0), so the duty never changes mid-period.
- While fan_on = 0, duty is forced to 0 immediately.

PWM:
- Prescaler 0..PWM_DIV-1. On its wrap, the 8-bit pwm_cnt increments, wrapping 255 -> 0.
- pwm_out = (pwm_cnt < duty), registered.
- duty 0 gives a constant low output. duty 255 gives high for 255 of 256 steps.
- Prescaler and pwm_cnt run continuously from reset.

Outputs:
- fan_on and state_led are registered from the state and update in the same cycle as the state register.

Test Plan:
- Use MS_CYCLES=10, PWM_DIV=2, CONFIRM_MS=5, HOLD_MS=8 for all scenarios.
1. Reset behaviour: assert reset_p mid-RUN with distance 10 -> the next posedge gives state_led 0001, fan_on 0, pwm_out 0, duty 0. After release with distance 10 and fan_en=1, ARM is entered within 2 clks.
2. Confirm and run: fan_en=1, speed_sel=2, distance 10 held -> RUN after 5 ms ticks. duty becomes 170 at the next pwm_cnt==0. Over one full period (512 clks), pwm_out is high for exactly 170*2 clks.
3. Short blip rejection: distance 10 for 3 ms ticks, then 0 -> ARM back to OFF, fan_on never asserted. A distance of 40 (in the hysteresis band) during ARM holds cnt unchanged.
4. Hold and resume: in RUN set distance 60 -> HOLD. Return to 10 after 4 ticks -> RUN with cnt cleared. Set 60 again for 8 ticks -> OFF, duty 0, pwm_out low.
5. Enable override: in HOLD drop fan_en -> OFF on the next clk. Reasserting fan_en with distance 10 goes to ARM, not RUN.
6. Speed boundaries: in RUN with speed_sel 0 -> pwm_out constant 0. Change to 3 mid-period -> the change applies only from the next pwm_cnt==0, after which pwm_out is low exactly 1 step (2 clks) per period.
